// File: rtl/adder_16bit.sv
// 16-bit adder with carry-in: two-level carry-lookahead (4 x 4-bit groups)
// feeding a single output register, one clock of latency.
module adder_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout,
  output logic        overflow
);

  logic [15:0] bit_g;
  logic [15:0] bit_p;
  logic [15:0] bit_c;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [3:0]  grp_c;

  logic [15:0] sum_next;
  logic        cout_next;
  logic        overflow_next;

  logic [15:0] sum_reg;
  logic        cout_reg;
  logic        overflow_reg;

  assign bit_g = a & b;
  assign bit_p = a ^ b;

  // First level: each group resolves its own carries from its group carry-in,
  // so no ripple ever crosses a group boundary.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_grp
      logic [3:0] g;
      logic [3:0] p;
      logic       ci;
      logic       c1;
      logic       c2;
      logic       c3;

      assign g  = bit_g[4*gi +: 4];
      assign p  = bit_p[4*gi +: 4];
      assign ci = grp_c[gi];

      assign c1 = g[0] | (p[0] & ci);
      assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);

      assign bit_c[4*gi +: 4] = {c3, c2, c1, ci};

      assign grp_g[gi] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                       | (p[3] & p[2] & p[1] & g[0]);
      assign grp_p[gi] = &p;
    end
  endgenerate

  // Second level: carries into groups 1..3 and the final carry-out.
  assign grp_c[0] = cin;
  assign grp_c[1] = grp_g[0] | (grp_p[0] & cin);
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0])
                  | (grp_p[1] & grp_p[0] & cin);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1])
                  | (grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
  assign cout_next = grp_g[3] | (grp_p[3] & grp_g[2])
                   | (grp_p[3] & grp_p[2] & grp_g[1])
                   | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                   | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);

  assign sum_next = bit_p ^ bit_c;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign overflow_next = bit_c[15] ^ cout_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_reg      <= 16'h0000;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      sum_reg      <= sum_next;
      cout_reg     <= cout_next;
      overflow_reg <= overflow_next;
    end
  end

  assign sum      = sum_reg;
  assign cout     = cout_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_adder_16bit.sv
// Self-checking bench for adder_16bit: directed boundary cases, pipelining,
// asynchronous reset and random vectors against an arithmetic reference.
module tb_adder_16bit;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  int total_cnt;
  int pass_cnt;

  adder_16bit dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {sum, cout, overflow} from plain 17-bit arithmetic.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci);
    logic [16:0] r;
    logic        ov;
    r  = {1'b0, x} + {1'b0, y} + {16'd0, ci};
    ov = (x[15] == y[15]) && (r[15] != x[15]);
    return {r[15:0], r[16], ov};
  endfunction

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                tag, obs[17:2], obs[1], obs[0], exp[17:2], exp[1], exp[0]);
  endtask

  task automatic step(input string tag, input logic [15:0] x, input logic [15:0] y,
                      input logic ci);
    @(negedge clk);
    a   = x;
    b   = y;
    cin = ci;
    @(posedge clk);
    #1;
    check(tag, {sum, cout, overflow}, model(x, y, ci));
    $display("%s: a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b", tag, x, y, ci, sum, cout, overflow);
  endtask

  logic [15:0] pa [4];
  logic [15:0] pb [4];
  logic        pc [4];
  logic [17:0] prev;

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    a   = 16'h1234;
    b   = 16'h1111;
    cin = 1'b0;
    rst = 1'b1;

    // Reset held while clocking: outputs stay zero.
    #1;
    check("reset_initial", {sum, cout, overflow}, 18'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_held", {sum, cout, overflow}, 18'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_release_hold", {sum, cout, overflow}, 18'd0);
    @(posedge clk);
    #1;
    check("reset_first_result", {sum, cout, overflow}, {16'h2345, 1'b0, 1'b0});
    $display("reset: sum=%h cout=%b ovf=%b", sum, cout, overflow);

    // Directed boundary cases, expected values written out as constants.
    step("pos_ovf", 16'h7FFF, 16'h0001, 1'b0);
    check("pos_ovf_const", {sum, cout, overflow}, {16'h8000, 1'b0, 1'b1});
    step("neg_ovf", 16'h8000, 16'h8000, 1'b0);
    check("neg_ovf_const", {sum, cout, overflow}, {16'h0000, 1'b1, 1'b1});
    step("neg_no_ovf", 16'hFFFF, 16'hFFFF, 1'b0);
    check("neg_no_ovf_const", {sum, cout, overflow}, {16'hFFFE, 1'b1, 1'b0});
    step("mixed_sign", 16'h7FFF, 16'h8000, 1'b0);
    check("mixed_sign_const", {sum, cout, overflow}, {16'hFFFF, 1'b0, 1'b0});
    step("all_ones_cin", 16'hFFFF, 16'hFFFF, 1'b1);
    check("all_ones_cin_const", {sum, cout, overflow}, {16'hFFFF, 1'b1, 1'b0});
    step("cin_full_ripple", 16'hFFFF, 16'h0000, 1'b1);
    check("cin_full_ripple_const", {sum, cout, overflow}, {16'h0000, 1'b1, 1'b0});
    step("cin_only", 16'h0000, 16'h0000, 1'b1);
    check("cin_only_const", {sum, cout, overflow}, {16'h0001, 1'b0, 1'b0});
    step("cin_group_cross", 16'h000F, 16'h0000, 1'b1);
    check("cin_group_cross_const", {sum, cout, overflow}, {16'h0010, 1'b0, 1'b0});
    step("cin_group2_cross", 16'h00FF, 16'h0000, 1'b1);
    check("cin_group2_cross_const", {sum, cout, overflow}, {16'h0100, 1'b0, 1'b0});
    step("cin_group3_cross", 16'h0FFF, 16'h0000, 1'b1);
    check("cin_group3_cross_const", {sum, cout, overflow}, {16'h1000, 1'b0, 1'b0});

    // Back-to-back operands: each result one edge later, previous result
    // still held right up to the next edge.
    pa = '{16'h1111, 16'hA5A5, 16'h7000, 16'hFFF0};
    pb = '{16'h2222, 16'h5A5A, 16'h1000, 16'h0010};
    pc = '{1'b0, 1'b1, 1'b0, 1'b1};
    prev = {sum, cout, overflow};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a   = pa[i];
      b   = pb[i];
      cin = pc[i];
      #1;
      check("pipe_hold", {sum, cout, overflow}, prev);
      @(posedge clk);
      #1;
      prev = model(pa[i], pb[i], pc[i]);
      check("pipe_result", {sum, cout, overflow}, prev);
      $display("pipe[%0d]: a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b",
               i, pa[i], pb[i], pc[i], sum, cout, overflow);
    end

    // Mid-stream reset clears outputs between edges, without waiting for clk.
    @(negedge clk);
    a   = 16'h4321;
    b   = 16'h1234;
    cin = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_result", {sum, cout, overflow}, model(16'h4321, 16'h1234, 1'b1));
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_clear", {sum, cout, overflow}, 18'd0);
    @(posedge clk);
    #1;
    check("async_rst_held", {sum, cout, overflow}, 18'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_rst_release", {sum, cout, overflow}, 18'd0);
    @(posedge clk);
    #1;
    check("async_rst_first", {sum, cout, overflow}, model(16'h4321, 16'h1234, 1'b1));
    $display("mid-stream reset: sum=%h cout=%b ovf=%b", sum, cout, overflow);

    // Random vectors.
    for (int i = 0; i < 10000; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rc;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      @(negedge clk);
      a   = ra;
      b   = rb;
      cin = rc;
      @(posedge clk);
      #1;
      check("random", {sum, cout, overflow}, model(ra, rb, rc));
    end
    $display("random: 10000 vectors applied");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
